// File: rtl/test_io_monitor.sv
// Data-bus shim between cpu and ram: passes normal traffic through and decodes a
// 3-word test-I/O window (EXIT, LOG, CYCLES). Log FIFO built only with TEST_IO_LOG_FIFO_EN.
module test_io_monitor #(
  parameter logic [31:0] IO_BASE        = 32'h0000_0F00,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [3:0]  mask,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [31:0] ram_a,
  output logic [3:0]  ram_mask,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd,
  output logic        log_valid,
  output logic [31:0] log_data,
  input  logic        log_ready,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] exit_code,
  output logic [31:0] cycle_count,
  output logic        log_overflow
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  localparam logic [29:0] EXIT_W  = IO_BASE[31:2];
  localparam logic [29:0] LOG_W   = IO_BASE[31:2] + 30'd1;
  localparam logic [29:0] CYC_W   = IO_BASE[31:2] + 30'd2;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  logic hit_exit, hit_log, hit_cyc, in_win;
  logic exit_wr, log_wr;

  assign hit_exit = (a[31:2] == EXIT_W);
  assign hit_log  = (a[31:2] == LOG_W);
  assign hit_cyc  = (a[31:2] == CYC_W);
  assign in_win   = hit_exit | hit_log | hit_cyc;
  assign exit_wr  = we & hit_exit & wd[0];
  assign log_wr   = we & hit_log;

  assign ram_a    = a;
  assign ram_mask = mask;
  assign ram_wd   = wd;
  assign ram_we   = we & ~in_win;

  always_comb begin
    rd = ram_rd;
    if (hit_cyc)
      rd = cycle_count;
    else if (hit_exit | hit_log)
      rd = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_RUN;
    else
      state <= state_next;
  end

  // An EXIT write on the final run cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    unique case (state)
      S_RUN: begin
        if (exit_wr)
          state_next = S_DONE;
        else if (cycle_count == TO_LAST)
          state_next = S_TIMEOUT;
      end
      S_DONE:    state_next = S_DONE;
      S_TIMEOUT: state_next = S_TIMEOUT;
      default:   state_next = S_RUN;
    endcase
  end

  always_comb begin
    done    = (state == S_DONE);
    timeout = (state == S_TIMEOUT);
    pass    = done & (exit_code == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      exit_code   <= '0;
    end else if (state == S_RUN) begin
      if (cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (exit_wr)
        exit_code <= wd[31:1];
    end
  end

`ifdef TEST_IO_LOG_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_C = (AW + 1)'(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_ok;

  assign full    = (count == FULL_C);
  assign pop     = log_ready & (count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = log_wr & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (log_wr & full & ~pop)
        log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wd;
  end

  assign log_valid = (count != '0);
  assign log_data  = mem[rd_ptr];
`else
  logic unused_log;
  assign unused_log   = log_ready ^ log_wr;
  assign log_valid    = 1'b0;
  assign log_data     = '0;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_test_io_monitor.sv
// Self-checking bench for test_io_monitor: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_test_io_monitor;

  localparam logic [31:0] IO_BASE = 32'h0000_0F00;
  localparam logic [31:0] EXIT_A  = IO_BASE;
  localparam logic [31:0] LOG_A   = IO_BASE + 32'd4;
  localparam logic [31:0] CYC_A   = IO_BASE + 32'd8;
  localparam int unsigned TO_MAIN = 4096;
  localparam int unsigned DEPTH   = 8;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [3:0]  mask;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] ram_a;
  logic [3:0]  ram_mask;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;
  logic        log_valid;
  logic [31:0] log_data;
  logic        log_ready;
  logic        done, pass, timeout;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;
  logic        log_overflow;

  logic        rst_t;
  logic [31:0] a_t;
  logic [3:0]  mask_t;
  logic        we_t;
  logic [31:0] wd_t;
  logic [31:0] rd_t;
  logic [31:0] ram_a_t;
  logic [3:0]  ram_mask_t;
  logic        ram_we_t;
  logic [31:0] ram_wd_t;
  logic [31:0] ram_rd_t;
  logic        log_valid_t;
  logic [31:0] log_data_t;
  logic        log_ready_t;
  logic        done_t, pass_t, timeout_t;
  logic [30:0] exit_code_t;
  logic [31:0] cycle_count_t;
  logic        log_overflow_t;

  test_io_monitor #(
    .IO_BASE(IO_BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_MAIN)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .mask(mask), .we(we), .wd(wd), .rd(rd),
    .ram_a(ram_a), .ram_mask(ram_mask), .ram_we(ram_we), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .log_valid(log_valid), .log_data(log_data),
    .log_ready(log_ready), .done(done), .pass(pass), .timeout(timeout),
    .exit_code(exit_code), .cycle_count(cycle_count), .log_overflow(log_overflow)
  );

  test_io_monitor #(
    .IO_BASE(IO_BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16)
  ) dut_t (
    .clk(clk), .rst(rst_t), .a(a_t), .mask(mask_t), .we(we_t), .wd(wd_t), .rd(rd_t),
    .ram_a(ram_a_t), .ram_mask(ram_mask_t), .ram_we(ram_we_t), .ram_wd(ram_wd_t),
    .ram_rd(ram_rd_t), .log_valid(log_valid_t), .log_data(log_data_t),
    .log_ready(log_ready_t), .done(done_t), .pass(pass_t), .timeout(timeout_t),
    .exit_code(exit_code_t), .cycle_count(cycle_count_t), .log_overflow(log_overflow_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM seen by the main instance.
  logic [31:0] ram_mem [256];
  logic        fill_req;
  assign ram_rd = ram_mem[ram_a[9:2]];

  function automatic logic [31:0] ram_init(input int unsigned i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= ram_init(i);
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_mask[b]) ram_mem[ram_a[9:2]][8*b +: 8] <= ram_wd[8*b +: 8];
    end
  end

  int unsigned n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    a = 32'h0; we = 1'b0; wd = 32'h0; mask = 4'hF; log_ready = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    idle_bus();
    rst = 1'b1;
    tick();
    if (check) begin
      #2;
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_pass", {31'b0, pass}, 32'd0);
      chk("rst_timeout", {31'b0, timeout}, 32'd0);
      chk("rst_exit_code", {1'b0, exit_code}, 32'd0);
      chk("rst_cycle_count", cycle_count, 32'd0);
      chk("rst_log_valid", {31'b0, log_valid}, 32'd0);
      chk("rst_log_overflow", {31'b0, log_overflow}, 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic ram_fill();
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ram_we;
  } vec_t;

  vec_t vecs [10];

  // Reference model state for the randomized run.
  logic [31:0] m_ram [256];
  logic [31:0] m_q [$];
  logic [31:0] m_cnt;
  logic [30:0] m_code;
  bit          m_done, m_to, m_ovf;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    fill_req = 1'b0;
    rst_t = 1'b1; a_t = 32'h0; mask_t = 4'hF; we_t = 1'b0; wd_t = 32'h0;
    ram_rd_t = 32'h0; log_ready_t = 1'b0;
    rst = 1'b1;
    idle_bus();

    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,         ram_init(64),  1'b0};
    vecs[1] = '{32'h0000_03FC, 1'b0, 32'h0,         ram_init(255), 1'b0};
    vecs[2] = '{32'h0000_0200, 1'b1, 32'h1111_2222, ram_init(128), 1'b1};
    vecs[3] = '{EXIT_A,        1'b0, 32'h0,         32'h0,         1'b0};
    vecs[4] = '{LOG_A,         1'b0, 32'h0,         32'h0,         1'b0};
    vecs[5] = '{EXIT_A,        1'b1, 32'hFFFF_FFFE, 32'h0,         1'b0};
    vecs[6] = '{LOG_A,         1'b1, 32'h0000_1234, 32'h0,         1'b0};
    vecs[7] = '{IO_BASE + 2,   1'b1, 32'h0000_0002, 32'h0,         1'b0};
    vecs[8] = '{IO_BASE + 12,  1'b0, 32'h0,         ram_init(195), 1'b0};
    vecs[9] = '{IO_BASE - 4,   1'b1, 32'h5555_AAAA, ram_init(191), 1'b1};

    ram_fill();

    // Bus decode table, applied while held in reset so the counter reads 0.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a; we = vecs[i].we; wd = vecs[i].wd;
      #2;
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].exp_ram_we});
      chk($sformatf("vec%0d_ram_a", i), ram_a, vecs[i].a);
      chk($sformatf("vec%0d_ram_wd", i), ram_wd, vecs[i].wd);
      tick();
    end
    a = CYC_A; we = 1'b0;
    #2;
    chk("vec_cyc_in_reset", rd, 32'd0);
    tick();

    // Reset state and idle counting.
    do_reset(1'b1);
    repeat (10) tick();
    #2;
    chk("idle10_count", cycle_count, 32'd10);
    chk("idle10_done", {31'b0, done}, 32'd0);
    chk("idle10_timeout", {31'b0, timeout}, 32'd0);

    do_reset(1'b0);
    repeat (5) tick();
    a = CYC_A;
    #2;
    chk("cycles_read_5", rd, 32'd5);

    // Passing exit at cycle 37; later exit ignored.
    do_reset(1'b0);
    repeat (37) tick();
    a = EXIT_A; we = 1'b1; wd = 32'h1;
    #2;
    chk("exit_ram_we", {31'b0, ram_we}, 32'd0);
    tick();
    we = 1'b0;
    #2;
    chk("exit1_done", {31'b0, done}, 32'd1);
    chk("exit1_pass", {31'b0, pass}, 32'd1);
    chk("exit1_code", {1'b0, exit_code}, 32'd0);
    chk("exit1_count", cycle_count, 32'd38);
    we = 1'b1; wd = 32'h7;
    tick();
    we = 1'b0;
    repeat (3) tick();
    #2;
    chk("exit7_ignored_code", {1'b0, exit_code}, 32'd0);
    chk("exit7_ignored_pass", {31'b0, pass}, 32'd1);
    chk("frozen_count", cycle_count, 32'd38);

    // Even EXIT write ignored, then failing exit code 10.
    do_reset(1'b0);
    a = EXIT_A; we = 1'b1; wd = 32'h14;
    tick();
    #2;
    chk("exit14_done", {31'b0, done}, 32'd0);
    wd = 32'h15;
    tick();
    we = 1'b0;
    #2;
    chk("exit15_done", {31'b0, done}, 32'd1);
    chk("exit15_code", {1'b0, exit_code}, 32'd10);
    chk("exit15_pass", {31'b0, pass}, 32'd0);

    // Log FIFO overflow and drain.
    do_reset(1'b0);
    for (int i = 1; i <= 9; i++) begin
      a = LOG_A; we = 1'b1; wd = 32'(i);
      tick();
    end
    we = 1'b0;
    #2;
`ifdef TEST_IO_LOG_FIFO_EN
    chk("log_full_valid", {31'b0, log_valid}, 32'd1);
    chk("log_full_head", log_data, 32'd1);
    chk("log_overflow", {31'b0, log_overflow}, 32'd1);
    log_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("log_pop%0d", i), log_data, 32'(i));
      tick();
      #2;
    end
    chk("log_drained_valid", {31'b0, log_valid}, 32'd0);
    chk("log_overflow_sticky", {31'b0, log_overflow}, 32'd1);

    // Push and pop together on a full FIFO: both accepted, no overflow.
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) begin
      a = LOG_A; we = 1'b1; wd = 32'(i);
      tick();
    end
    wd = 32'd9; log_ready = 1'b1;
    tick();
    we = 1'b0; log_ready = 1'b0;
    #2;
    chk("full_pushpop_overflow", {31'b0, log_overflow}, 32'd0);
    chk("full_pushpop_head", log_data, 32'd2);
    log_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("pushpop_pop%0d", i), log_data, 32'(i));
      tick();
      #2;
    end
    chk("pushpop_drained", {31'b0, log_valid}, 32'd0);
    log_ready = 1'b0;
`else
    chk("nofifo_valid", {31'b0, log_valid}, 32'd0);
    chk("nofifo_data", log_data, 32'd0);
    chk("nofifo_overflow", {31'b0, log_overflow}, 32'd0);
`endif

    // RAM pass-through.
    do_reset(1'b0);
    a = 32'h100; we = 1'b1; wd = 32'hDEAD_BEEF; mask = 4'hF;
    tick();
    we = 1'b0;
    #2;
    chk("ram_load", rd, 32'hDEAD_BEEF);

    // Timeout on the short-timeout instance.
    rst_t = 1'b1;
    tick();
    rst_t = 1'b0;
    repeat (15) tick();
    #2;
    chk("to15_timeout", {31'b0, timeout_t}, 32'd0);
    chk("to15_count", cycle_count_t, 32'd15);
    tick();
    #2;
    chk("to16_timeout", {31'b0, timeout_t}, 32'd1);
    chk("to16_count", cycle_count_t, 32'd16);
    chk("to16_done", {31'b0, done_t}, 32'd0);
    repeat (3) tick();
    #2;
    chk("to_frozen", cycle_count_t, 32'd16);
    rst_t = 1'b1;
    tick();
    #2;
    chk("to_rst_timeout", {31'b0, timeout_t}, 32'd0);
    chk("to_rst_count", cycle_count_t, 32'd0);
    rst_t = 1'b0;
    repeat (3) tick();
    #2;
    chk("to_rerun_count", cycle_count_t, 32'd3);
    chk("to_rerun_timeout", {31'b0, timeout_t}, 32'd0);

    // Exit on the last run cycle beats the timeout.
    rst_t = 1'b1;
    tick();
    rst_t = 1'b0;
    repeat (15) tick();
    a_t = EXIT_A; we_t = 1'b1; wd_t = 32'h1;
    tick();
    we_t = 1'b0;
    #2;
    chk("race_done", {31'b0, done_t}, 32'd1);
    chk("race_timeout", {31'b0, timeout_t}, 32'd0);

    // Randomized run against the reference model.
    ram_fill();
    for (int i = 0; i < 256; i++) m_ram[i] = ram_init(i);
    do_reset(1'b0);
    m_q.delete();
    m_cnt = 32'd0; m_code = '0; m_done = 0; m_to = 0; m_ovf = 0;
    for (int c = 0; c < 600; c++) begin
      int unsigned op;
      bit          in_win;
      logic [31:0] exp_rd;
      op = $urandom_range(0, 99);
      mask = 4'($urandom);
      wd = $urandom;
      log_ready = 1'($urandom);
      we = 1'b0;
      a = 32'($urandom_range(0, 255)) << 2;
      if (op < 30) begin
        we = 1'b0;
      end else if (op < 50) begin
        we = 1'b1;
      end else if (op < 65) begin
        a = LOG_A; we = 1'b1;
      end else if (op < 75) begin
        a = CYC_A;
      end else if (op < 77) begin
        a = EXIT_A; we = 1'b1;
      end else if (op < 85) begin
        a = (op[0]) ? EXIT_A : LOG_A;
      end

      in_win = (a >= IO_BASE) && (a < IO_BASE + 32'd12);
      if (!in_win) exp_rd = m_ram[a[9:2]];
      else if (a == CYC_A) exp_rd = m_cnt;
      else exp_rd = 32'd0;
      #2;
      chk("rnd_rd", rd, exp_rd);
      chk("rnd_ram_we", {31'b0, ram_we}, {31'b0, we && !in_win});
      chk("rnd_done", {31'b0, done}, {31'b0, m_done});
      chk("rnd_pass", {31'b0, pass}, {31'b0, m_done && (m_code == 0)});
      chk("rnd_timeout", {31'b0, timeout}, {31'b0, m_to});
      chk("rnd_exit_code", {1'b0, exit_code}, {1'b0, m_code});
      chk("rnd_cycle_count", cycle_count, m_cnt);
`ifdef TEST_IO_LOG_FIFO_EN
      chk("rnd_log_valid", {31'b0, log_valid}, {31'b0, m_q.size() > 0});
      if (m_q.size() > 0) chk("rnd_log_data", log_data, m_q[0]);
      chk("rnd_log_overflow", {31'b0, log_overflow}, {31'b0, m_ovf});
`else
      chk("rnd_log_valid", {31'b0, log_valid}, 32'd0);
      chk("rnd_log_overflow", {31'b0, log_overflow}, 32'd0);
`endif

      if (!m_done && !m_to) begin
        if (we && a == EXIT_A && wd[0]) begin
          m_done = 1;
          m_code = wd[31:1];
        end else if (m_cnt == 32'(TO_MAIN - 1)) begin
          m_to = 1;
        end
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
`ifdef TEST_IO_LOG_FIFO_EN
      if (log_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (we && a == LOG_A) begin
        if (m_q.size() < DEPTH) m_q.push_back(wd);
        else m_ovf = 1;
      end
`endif
      if (we && !in_win)
        for (int b = 0; b < 4; b++)
          if (mask[b]) m_ram[a[9:2]][8*b +: 8] = wd[8*b +: 8];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
